regfile_2w_sb: RTL and testbench
================================

// Module: regfile_2w_sb
// PURPOSE
//  Parametrised successor register file: 2 async read ports, 2 write ports (W0 = ALU
//  writeback, W1 = long-latency load/mul writeback), same-cycle write-to-read bypass,
//  hardwired-zero register 0 and a per-register busy scoreboard for hazard stalls.
//  Sits between decode (reads, issue) and writeback; its Busy outputs drive the stall logic.
// PARAMETERS
//  ADDR  5         address width
//  NUMB  1<<ADDR   register count (register 0 included)
//  SIZE  64        data width
// PORTS
//  Clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  R_Addr_A     in   ADDR  read port A address
//  R_Addr_B     in   ADDR  read port B address
//  R_Data_A     out  SIZE  read data A (combinational, bypassed)
//  R_Data_B     out  SIZE  read data B (combinational, bypassed)
//  Busy_A       out  1     R_Addr_A has a pending W1 write (combinational)
//  Busy_B       out  1     R_Addr_B has a pending W1 write (combinational)
//  W0_en        in   1     write port 0 enable
//  W0_Addr      in   ADDR  write port 0 address
//  W0_Data      in   SIZE  write port 0 data
//  W1_en        in   1     write port 1 enable; also clears the busy bit of W1_Addr
//  W1_Addr      in   ADDR  write port 1 address
//  W1_Data      in   SIZE  write port 1 data
//  Issue_en     in   1     a long-latency op issued; mark Issue_Addr busy
//  Issue_Addr   in   ADDR  destination of the issued op
//  Busy_Cnt     out  ADDR+1 number of busy registers (registered)
//  Wr_Conflict  out  1     registered pulse: W0 and W1 wrote same nonzero addr last cycle
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): all registers = 0, all busy bits = 0,
//    Busy_Cnt = 0, Wr_Conflict = 0. Writes/issues in a cycle where reset is asserted are lost.
//  - Register 0: always reads 0, never written, never busy; writes/issues to addr 0 are ignored
//    (no busy set, no count change, no conflict flag).
//  - Write: on rising edge, Wn_en & Wn_Addr!=0 -> REG[Wn_Addr] <= Wn_Data.
//    W0 and W1 to same addr in same cycle: W1 data wins; Wr_Conflict = 1 for the next cycle only.
//  - Read: R_Data_X = 0 if addr 0; else W1_Data if W1_en & W1_Addr==addr; else W0_Data if
//    W0_en & W0_Addr==addr; else REG[addr]. Zero-cycle latency; bypass priority matches write priority.
//  - Scoreboard: busy[a] set on edge when Issue_en & Issue_Addr==a (a!=0); cleared on edge when
//    W1_en & W1_Addr==a. Issue and W1 to same addr same cycle: set wins (new op outstanding);
//    busy stays 1, count unchanged net. Issue to already-busy register: stays 1, count unchanged.
//    W1 to non-busy register: data written, busy unchanged, count unchanged. W0 never touches busy.
//  - Busy_X = busy[addr] & ~(W1_en & W1_Addr==addr) (W1 completion this cycle releases the stall,
//    data is bypassed). Addr 0 -> Busy_X = 0.
//  - Busy_Cnt: registered popcount-equivalent counter; +1 on a 0->1 busy transition, -1 on 1->0,
//    both in same cycle (different addrs) -> unchanged. Range 0..NUMB-1; never wraps.
// TESTING
//  1 Reset then read all addrs -> R_Data 0, Busy 0, Busy_Cnt 0; assert rst_n low mid-run after
//    writes -> all outputs 0 immediately (no clock edge needed).
//  2 W0 addr 5 = 64'hDEAD_BEEF; same cycle R_Addr_A=5 -> R_Data_A=DEAD_BEEF (bypass); next cycle
//    from array. Write addr 0 = 64'h1 -> R_Data of addr 0 stays 0.
//  3 W0 and W1 both addr 7 (data 0x11 / 0x22) -> R_Data 0x22 same cycle and after; Wr_Conflict 1
//    for exactly one cycle; same to addr 0 -> Wr_Conflict stays 0.
//  4 Issue addr 3 -> next cycle Busy_A(3)=1, Busy_Cnt=1; W1 addr 3 = 0x55 -> Busy_A=0 and
//    R_Data_A=0x55 that cycle; after edge Busy_Cnt=0.
//  5 Issue addr 4 and W1 addr 4 same cycle while busy[4]=1 -> busy stays 1, Busy_Cnt unchanged;
//    Issue addr 6 with W1 addr 9 (busy) same cycle -> Busy_Cnt unchanged.
//  6 Issue all 31 nonzero addrs -> Busy_Cnt=31; reissue any -> stays 31; random W0/W1/Issue traffic
//    vs. reference model for 10k cycles -> zero mismatches.

Source files
------------

// File: rtl/regfile_2w_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2w_sb
//  Description : 2R/2W register file with write-to-read bypass, hardwired
//                zero register and a busy scoreboard for long-latency ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2w_sb #(
    parameter int ADDR = 5,
    parameter int NUMB = 1 << ADDR,
    parameter int SIZE = 64
) (
    input  logic            Clk,
    input  logic            rst_n,
    input  logic [ADDR-1:0] R_Addr_A,
    input  logic [ADDR-1:0] R_Addr_B,
    output logic [SIZE-1:0] R_Data_A,
    output logic [SIZE-1:0] R_Data_B,
    output logic            Busy_A,
    output logic            Busy_B,
    input  logic            W0_en,
    input  logic [ADDR-1:0] W0_Addr,
    input  logic [SIZE-1:0] W0_Data,
    input  logic            W1_en,
    input  logic [ADDR-1:0] W1_Addr,
    input  logic [SIZE-1:0] W1_Data,
    input  logic            Issue_en,
    input  logic [ADDR-1:0] Issue_Addr,
    output logic [ADDR:0]   Busy_Cnt,
    output logic            Wr_Conflict
);

    localparam logic [ADDR:0] c_CNT_ONE = {{ADDR{1'b0}}, 1'b1};

    logic [SIZE-1:0] r_mem_q [NUMB];
    logic [SIZE-1:0] r_mem_d [NUMB];
    logic [NUMB-1:0] r_busy_q;
    logic [NUMB-1:0] r_busy_d;
    logic [ADDR:0]   r_busy_cnt_q;
    logic [ADDR:0]   r_busy_cnt_d;
    logic            r_conflict_q;
    logic            r_conflict_d;

    logic            w_w0_v;
    logic            w_w1_v;
    logic            w_issue_v;
    logic            w_inc;
    logic            w_dec;
    logic [ADDR-1:0] w_raddr [2];
    logic [SIZE-1:0] w_rdata [2];
    logic            w_rbusy [2];

    // Address 0 is never a real destination, so every qualifier excludes it.
    assign w_w0_v    = W0_en    && (W0_Addr    != '0);
    assign w_w1_v    = W1_en    && (W1_Addr    != '0);
    assign w_issue_v = Issue_en && (Issue_Addr != '0);

    // Count follows busy-bit transitions; an issue landing on the W1 target keeps it busy.
    assign w_inc = w_issue_v && !r_busy_q[Issue_Addr];
    assign w_dec = w_w1_v && r_busy_q[W1_Addr] && !(w_issue_v && (Issue_Addr == W1_Addr));

    always_comb begin
        r_mem_d = r_mem_q;
        if (w_w0_v) r_mem_d[W0_Addr] = W0_Data;
        if (w_w1_v) r_mem_d[W1_Addr] = W1_Data;

        r_busy_d = r_busy_q;
        if (w_w1_v)    r_busy_d[W1_Addr]    = 1'b0;
        if (w_issue_v) r_busy_d[Issue_Addr] = 1'b1;

        r_busy_cnt_d = r_busy_cnt_q;
        case ({w_inc, w_dec})
            2'b10:   r_busy_cnt_d = r_busy_cnt_q + c_CNT_ONE;
            2'b01:   r_busy_cnt_d = r_busy_cnt_q - c_CNT_ONE;
            default: r_busy_cnt_d = r_busy_cnt_q;
        endcase

        r_conflict_d = w_w0_v && w_w1_v && (W0_Addr == W1_Addr);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMB; i++) r_mem_q[i] <= '0;
            r_busy_q     <= '0;
            r_busy_cnt_q <= '0;
            r_conflict_q <= 1'b0;
        end else begin
            r_mem_q      <= r_mem_d;
            r_busy_q     <= r_busy_d;
            r_busy_cnt_q <= r_busy_cnt_d;
            r_conflict_q <= r_conflict_d;
        end
    end

    assign w_raddr[0] = R_Addr_A;
    assign w_raddr[1] = R_Addr_B;

    // Bypass priority mirrors write priority: W1 over W0 over the array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_mem_q[w_raddr[p]];
            if (w_raddr[p] == '0)
                w_rdata[p] = '0;
            else if (w_w1_v && (W1_Addr == w_raddr[p]))
                w_rdata[p] = W1_Data;
            else if (w_w0_v && (W0_Addr == w_raddr[p]))
                w_rdata[p] = W0_Data;

            w_rbusy[p] = (w_raddr[p] != '0) && r_busy_q[w_raddr[p]] &&
                         !(w_w1_v && (W1_Addr == w_raddr[p]));
        end
    end

    assign R_Data_A    = w_rdata[0];
    assign R_Data_B    = w_rdata[1];
    assign Busy_A      = w_rbusy[0];
    assign Busy_B      = w_rbusy[1];
    assign Busy_Cnt    = r_busy_cnt_q;
    assign Wr_Conflict = r_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_2w_sb
//  Description : Scoreboard testbench for regfile_2w_sb against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2w_sb;

    localparam int ADDR = 5;
    localparam int NUMB = 32;
    localparam int SIZE = 64;

    logic            Clk = 1'b0;
    logic            rst_n;
    logic [ADDR-1:0] R_Addr_A, R_Addr_B;
    logic [SIZE-1:0] R_Data_A, R_Data_B;
    logic            Busy_A, Busy_B;
    logic            W0_en, W1_en, Issue_en;
    logic [ADDR-1:0] W0_Addr, W1_Addr, Issue_Addr;
    logic [SIZE-1:0] W0_Data, W1_Data;
    logic [ADDR:0]   Busy_Cnt;
    logic            Wr_Conflict;

    always #5 Clk = ~Clk;

    regfile_2w_sb #(.ADDR(ADDR), .NUMB(NUMB), .SIZE(SIZE)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .Busy_A(Busy_A), .Busy_B(Busy_B),
        .W0_en(W0_en), .W0_Addr(W0_Addr), .W0_Data(W0_Data),
        .W1_en(W1_en), .W1_Addr(W1_Addr), .W1_Data(W1_Data),
        .Issue_en(Issue_en), .Issue_Addr(Issue_Addr),
        .Busy_Cnt(Busy_Cnt), .Wr_Conflict(Wr_Conflict)
    );

    typedef struct {
        logic [SIZE-1:0] da;
        logic [SIZE-1:0] db;
        logic            ba;
        logic            bb;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [SIZE-1:0] m_mem  [NUMB];
    bit              m_busy [NUMB];
    bit              m_conf;

    task automatic chk(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NUMB; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [SIZE-1:0] m_read(input logic [ADDR-1:0] a);
        if (a == 0) return '0;
        if (W1_en && W1_Addr == a) return W1_Data;
        if (W0_en && W0_Addr == a) return W0_Data;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [ADDR-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(W1_en && W1_Addr == a);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NUMB; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    function automatic logic [ADDR-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return ADDR'($urandom_range(0, 3));
        return ADDR'($urandom_range(0, NUMB - 1));
    endfunction

    // Called just after a rising edge; drives one cycle and checks both comb and registered outputs.
    task automatic step(input logic w0e, input logic [ADDR-1:0] w0a, input logic [SIZE-1:0] w0d,
                        input logic w1e, input logic [ADDR-1:0] w1a, input logic [SIZE-1:0] w1d,
                        input logic ie,  input logic [ADDR-1:0] ia,
                        input logic [ADDR-1:0] ra, input logic [ADDR-1:0] rb);
        exp_t e;
        exp_t o;
        W0_en = w0e; W0_Addr = w0a; W0_Data = w0d;
        W1_en = w1e; W1_Addr = w1a; W1_Data = w1d;
        Issue_en = ie; Issue_Addr = ia;
        R_Addr_A = ra; R_Addr_B = rb;
        e.da = m_read(ra);  e.db = m_read(rb);
        e.ba = m_rbusy(ra); e.bb = m_rbusy(rb);
        exp_q.push_back(e);
        #4;
        o = exp_q.pop_front();
        chk("rdata_a", R_Data_A, o.da);
        chk("rdata_b", R_Data_B, o.db);
        chk("busy_a", {63'd0, Busy_A}, {63'd0, o.ba});
        chk("busy_b", {63'd0, Busy_B}, {63'd0, o.bb});
        @(posedge Clk);
        if (W0_en && W0_Addr != 0) m_mem[W0_Addr] = W0_Data;
        if (W1_en && W1_Addr != 0) m_mem[W1_Addr] = W1_Data;
        if (W1_en && W1_Addr != 0) m_busy[W1_Addr] = 1'b0;
        if (Issue_en && Issue_Addr != 0) m_busy[Issue_Addr] = 1'b1;
        m_conf = W0_en && W1_en && W0_Addr == W1_Addr && W0_Addr != 0;
        #1;
        chk("busy_cnt", SIZE'(Busy_Cnt), SIZE'(m_cnt()));
        chk("wr_conflict", {63'd0, Wr_Conflict}, {63'd0, m_conf});
    endtask

    task automatic idle_inputs();
        W0_en = 0; W0_Addr = '0; W0_Data = '0;
        W1_en = 0; W1_Addr = '0; W1_Data = '0;
        Issue_en = 0; Issue_Addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        R_Addr_A = '0; R_Addr_B = '0;
        mdl_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_cnt", SIZE'(Busy_Cnt), '0);
        chk("rst_conf", {63'd0, Wr_Conflict}, '0);
        rst_n = 1'b1;

        // Reset contents on every address
        for (int i = 0; i < NUMB; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, ADDR'(i), ADDR'(NUMB - 1 - i));

        // Bypass, then array read, then addr 0 stays zero
        step(1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("t2_array", R_Data_A, 64'hDEAD_BEEF);
        step(1, 0, 64'h1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

        // Same-address dual write: W1 wins, conflict pulses once
        step(1, 7, 64'h11, 1, 7, 64'h22, 0, 0, 7, 7);
        chk("t3_pulse", {63'd0, Wr_Conflict}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("t3_pulse_end", {63'd0, Wr_Conflict}, 64'd0);
        step(1, 0, 64'h11, 1, 0, 64'h22, 0, 0, 0, 7);

        // Issue then completion through W1
        step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        chk("t4_cnt1", SIZE'(Busy_Cnt), 64'd1);
        step(0, 0, 0, 1, 3, 64'h55, 0, 0, 3, 0);
        chk("t4_cnt0", SIZE'(Busy_Cnt), 64'd0);

        // Issue colliding with W1 completion
        step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        step(0, 0, 0, 1, 4, 64'h44, 1, 4, 4, 4);
        step(0, 0, 0, 0, 0, 0, 1, 9, 4, 9);
        step(0, 0, 0, 1, 9, 64'h99, 1, 6, 9, 6);
        chk("t5_cnt", SIZE'(Busy_Cnt), 64'd2);

        // Asynchronous reset mid-run: no edge needed, writes during reset are lost
        idle_inputs();
        R_Addr_A = 7; R_Addr_B = 4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_da", R_Data_A, '0);
        chk("arst_db", R_Data_B, '0);
        chk("arst_bb", {63'd0, Busy_B}, '0);
        chk("arst_cnt", SIZE'(Busy_Cnt), '0);
        chk("arst_conf", {63'd0, Wr_Conflict}, '0);
        W0_en = 1; W0_Addr = 7; W0_Data = 64'hFF;
        Issue_en = 1; Issue_Addr = 8;
        @(posedge Clk);
        #1;
        idle_inputs();
        chk("arst_hold_cnt", SIZE'(Busy_Cnt), '0);
        #3;
        rst_n = 1'b1;
        mdl_reset();
        @(posedge Clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 8);

        // Every register busy, then reissue
        for (int i = 1; i < NUMB; i++)
            step(0, 0, 0, 0, 0, 0, 1, ADDR'(i), ADDR'(i), 0);
        chk("t6_cnt31", SIZE'(Busy_Cnt), 64'd31);
        step(0, 0, 0, 0, 0, 0, 1, 17, 17, 0);
        chk("t6_reissue", SIZE'(Busy_Cnt), 64'd31);

        // Random traffic against the model
        for (int k = 0; k < 10000; k++)
            step($urandom_range(0, 1) == 1, rnd_addr(), {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, rnd_addr(), {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, rnd_addr(),
                 rnd_addr(), rnd_addr());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
